combo_entry_capture: RTL and testbench

Upstream input stage of the combination-lock datapath. It synchronises the digit switches and the enter pushbutton, debounces the button, and validates each two-digit entry as BCD. It sequences accepted entries into three code slots and hands the completed 24-bit code, plus strobes, to the lock/display stage. The "00" entry clears the sequence; an idle timeout abandons a partial code.

---
 rtl/combo_entry_capture_pkg.sv | 24 ++
 rtl/combo_entry_capture_key_debounce.sv | 79 +++++++
 rtl/combo_entry_capture.sv | 143 ++++++++++++++
 tb/tb_combo_entry_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_entry_capture_pkg.sv
// Shared types and constants for the combination-lock entry datapath.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package combo_pkg;

   // Slot FSM: the encoding doubles as the "next slot to fill" index.
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_e;

   localparam logic [7:0] CLEAR_PAIR = 8'h00;
   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         SLOT_COUNT = 3;

   // {pair0, pair1, pair2}, pair0 in the top byte; shared with the lock/display stage.
   typedef logic [8*SLOT_COUNT-1:0] code_word_t;

   function automatic logic is_bcd_pair(input logic [7:0] p);
      return (p[7:4] <= BCD_MAX) && (p[3:0] <= BCD_MAX);
   endfunction

endpackage

// File: rtl/combo_entry_capture_key_debounce.sv
// Synchronise and debounce an active-low key; emit a one-cycle press pulse.
// Latency: press_o rises 2 + DEBOUNCE_CYCLES cycles after key_n_i settles low.
// Backpressure: none; at most one pulse per debounced 1->0 transition.
//
// Ports: clk_i, rst_i (async, active-high), key_n_i (raw, asynchronous),
//        press_o (registered one-cycle pulse).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_n_i,
   output logic press_o
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   // Two extra cycles cover the synchroniser flops, which leave reset as "released".
   localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] arm_cnt_q, arm_cnt_d;
   logic          press_q, press_d;

   always_comb begin
      level_d   = level_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      armed_d   = armed_q;
      arm_cnt_d = arm_cnt_q;

      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = sync_q[1];
         // Only the released->pressed edge is an event, and only once armed.
         press_d = armed_q & level_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // A key held down through reset must be seen released before it can
      // generate a press; otherwise reset release would look like a new press.
      if (!armed_q) begin
         if (!sync_q[1]) begin
            arm_cnt_d = '0;
         end else if (arm_cnt_q == ARM_LAST) begin
            armed_d = 1'b1;
         end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q    <= 2'b11;
         level_q   <= 1'b1;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         arm_cnt_q <= '0;
         press_q   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_n_i};
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         arm_cnt_q <= arm_cnt_d;
         press_q   <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/combo_entry_capture.sv
// Entry capture: sync switches, debounce enter, validate BCD pairs, fill 3 code slots.
// Latency: strobes appear 3 + DEBOUNCE_CYCLES cycles after enter_n settles low.
// Backpressure: none; outputs are one-cycle strobes plus held entry_pair/slot/code_word.
//
// Ports: clock, reset (async, active-high), A/B (tens/ones digit switches),
//        enter_n (raw active-low key); entry_pair, entry_stb, slot, code_word,
//        code_valid, clear_stb, digit_err, timeout_stb (all registered).
module combo_entry_capture
   import combo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 250000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       enter_n,
   output logic [7:0] entry_pair,
   output logic       entry_stb,
   output logic [1:0] slot,
   output code_word_t code_word,
   output logic       code_valid,
   output logic       clear_stb,
   output logic       digit_err,
   output logic       timeout_stb
);

   localparam int            IW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

   logic [7:0] ab_meta_q, ab_sync_q;
   logic       press;

   state_e     state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   code_word_t code_q, code_d;
   logic [7:0] pair_q, pair_d;
   logic       entry_q, entry_d;
   logic       valid_q, valid_d;
   logic       clear_q, clear_d;
   logic       err_q, err_d;
   logic       tmo_q, tmo_d;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk_i   (clock),
      .rst_i   (reset),
      .key_n_i (enter_n),
      .press_o (press)
   );

   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      code_d  = code_q;
      pair_d  = pair_q;
      entry_d = 1'b0;
      valid_d = 1'b0;
      clear_d = 1'b0;
      err_d   = 1'b0;
      tmo_d   = 1'b0;

      if (press) begin
         // A press always restarts the idle window, so it beats a same-cycle expiry.
         idle_d = '0;
         if (ab_sync_q == CLEAR_PAIR) begin
            clear_d = 1'b1;
            code_d  = '0;
            state_d = S0;
         end else if (!is_bcd_pair(ab_sync_q)) begin
            err_d = 1'b1;
         end else begin
            entry_d = 1'b1;
            pair_d  = ab_sync_q;
            case (state_q)
               S0: begin
                  code_d  = {ab_sync_q, 16'h0000};
                  state_d = S1;
               end
               S1: begin
                  code_d[15:8] = ab_sync_q;
                  state_d      = S2;
               end
               S2: begin
                  code_d[7:0] = ab_sync_q;
                  valid_d     = 1'b1;
                  state_d     = S0;
               end
               default: state_d = S0;
            endcase
         end
      end else if (state_q == S0 || TIMEOUT_CYCLES == 0) begin
         idle_d = '0;
      end else if (idle_q == IDLE_LAST) begin
         tmo_d   = 1'b1;
         code_d  = '0;
         state_d = S0;
         idle_d  = '0;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ab_meta_q <= '0;
         ab_sync_q <= '0;
         state_q   <= S0;
         idle_q    <= '0;
         code_q    <= '0;
         pair_q    <= '0;
         entry_q   <= 1'b0;
         valid_q   <= 1'b0;
         clear_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         ab_meta_q <= {A, B};
         ab_sync_q <= ab_meta_q;
         state_q   <= state_d;
         idle_q    <= idle_d;
         code_q    <= code_d;
         pair_q    <= pair_d;
         entry_q   <= entry_d;
         valid_q   <= valid_d;
         clear_q   <= clear_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

   assign entry_pair  = pair_q;
   assign entry_stb   = entry_q;
   assign slot        = state_q;
   assign code_word   = code_q;
   assign code_valid  = valid_q;
   assign clear_stb   = clear_q;
   assign digit_err   = err_q;
   assign timeout_stb = tmo_q;

endmodule

// File: tb/tb_combo_entry_capture.sv
module tb_combo_entry_capture;

   localparam int DEB = 4;
   localparam int TMO = 50;
   localparam int LAT = DEB + 3;   // enter_n fall to strobe, in cycles

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  A = 4'd0;
   logic [3:0]  B = 4'd0;
   logic        enter_n = 1'b1;
   logic [7:0]  entry_pair;
   logic        entry_stb;
   logic [1:0]  slot;
   logic [23:0] code_word;
   logic        code_valid, clear_stb, digit_err, timeout_stb;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: event-level view of the entry sequence.
   logic [7:0] m_p [3];
   int         m_slot;
   logic [7:0] m_last_pair;
   int         m_last_evt;
   bit         pend;
   int         pend_cyc;
   logic [7:0] pend_pair;
   bit         noise;
   int         fall_cyc, stb_cyc, tmo_cyc, n_stb, mark;
   int         c0;

   always #5 clock = ~clock;

   combo_entry_capture #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .A           (A),
      .B           (B),
      .enter_n     (enter_n),
      .entry_pair  (entry_pair),
      .entry_stb   (entry_stb),
      .slot        (slot),
      .code_word   (code_word),
      .code_valid  (code_valid),
      .clear_stb   (clear_stb),
      .digit_err   (digit_err),
      .timeout_stb (timeout_stb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_p[0] = 8'h00; m_p[1] = 8'h00; m_p[2] = 8'h00;
      m_slot = 0; m_last_pair = 8'h00; m_last_evt = 0; pend = 0;
   endtask

   // Advance one cycle, update the model, compare every output.
   task automatic tick();
      bit e_entry, e_valid, e_clear, e_err, e_tmo;
      logic [23:0] e_code;
      @(negedge clock);
      cyc++;
      e_entry = 0; e_valid = 0; e_clear = 0; e_err = 0; e_tmo = 0;
      if (reset) begin
         model_reset();
      end else if (pend && pend_cyc == cyc) begin
         pend = 0;
         m_last_evt = cyc;
         if (pend_pair == 8'h00) begin
            e_clear = 1;
            m_slot = 0;
            m_p[0] = 8'h00; m_p[1] = 8'h00; m_p[2] = 8'h00;
         end else if (pend_pair[7:4] > 4'd9 || pend_pair[3:0] > 4'd9) begin
            e_err = 1;
         end else begin
            e_entry = 1;
            m_last_pair = pend_pair;
            if (m_slot == 0) begin
               m_p[0] = pend_pair; m_p[1] = 8'h00; m_p[2] = 8'h00;
            end else begin
               m_p[m_slot] = pend_pair;
            end
            if (m_slot == 2) e_valid = 1;
            m_slot = (m_slot + 1) % 3;
         end
      end else if (m_slot != 0 && cyc - m_last_evt == TMO) begin
         e_tmo = 1;
         m_slot = 0;
         m_p[0] = 8'h00; m_p[1] = 8'h00; m_p[2] = 8'h00;
      end
      e_code = {m_p[0], m_p[1], m_p[2]};

      if (entry_stb === 1'b1) begin stb_cyc = cyc; n_stb++; end
      if (timeout_stb === 1'b1) tmo_cyc = cyc;

      chk("entry_stb",   entry_stb,   e_entry);
      chk("code_valid",  code_valid,  e_valid);
      chk("clear_stb",   clear_stb,   e_clear);
      chk("digit_err",   digit_err,   e_err);
      chk("timeout_stb", timeout_stb, e_tmo);
      chk("entry_pair",  entry_pair,  m_last_pair);
      chk("slot",        slot,        m_slot);
      chk("code_word",   code_word,   e_code);
   endtask

   // Clean press: digits set with the fall, held low `hold` cycles, then released `gap` cycles.
   task automatic press(input logic [3:0] a, input logic [3:0] b, input int hold, input int gap);
      A = a; B = b; enter_n = 1'b0;
      pend = 1; pend_cyc = cyc + LAT; pend_pair = {a, b}; fall_cyc = cyc;
      repeat (hold) tick();
      enter_n = 1'b1;
      repeat (gap) begin
         tick();
         if (noise && !pend) begin
            A = 4'($urandom); B = 4'($urandom);
         end
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_slot"},    slot,       0);
      chk({tag, "_code"},    code_word,  0);
      chk({tag, "_pair"},    entry_pair, 0);
      chk({tag, "_strobes"}, {entry_stb, code_valid, clear_stb, digit_err, timeout_stb}, 0);
      model_reset();
      repeat (3) tick();
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      noise = 0; n_stb = 0; stb_cyc = 0; tmo_cyc = 0; fall_cyc = 0;

      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      repeat (12) tick();

      // Basic three-entry code and latency
      press(4'd2, 4'd8, 8, 8);
      chk("latency", stb_cyc - fall_cyc, LAT);
      chk("slot_after_28", slot, 1);
      press(4'd1, 4'd9, 8, 8);
      chk("slot_after_19", slot, 2);
      press(4'd9, 4'd6, 8, 8);
      chk("code_281996", code_word, 24'h281996);
      chk("slot_after_96", slot, 0);

      // Bounce: toggles every 2 cycles then a held press -> exactly one entry
      mark = n_stb;
      repeat (5) begin
         enter_n = 1'b0; repeat (2) tick();
         enter_n = 1'b1; repeat (2) tick();
      end
      press(4'd3, 4'd4, 10, 10);
      chk("bounce_one_event", n_stb - mark, 1);
      mark = n_stb;
      enter_n = 1'b0; repeat (3) tick();
      enter_n = 1'b1; repeat (15) tick();
      chk("glitch_no_event", n_stb - mark, 0);
      press(4'd0, 4'd0, 8, 8);

      // Non-BCD entry leaves the sequence alone
      press(4'd2, 4'd8, 8, 8);
      press(4'd1, 4'd10, 8, 8);
      chk("err_slot_kept", slot, 1);
      press(4'd1, 4'd9, 8, 8);
      chk("slot_after_err", slot, 2);
      chk("code_2819", code_word[23:8], 16'h2819);

      // Clear from S2, then clear again in S0
      press(4'd0, 4'd0, 8, 8);
      chk("clear_slot", slot, 0);
      chk("clear_code", code_word, 0);
      press(4'd0, 4'd0, 8, 8);

      // Idle timeout
      press(4'd2, 4'd8, 8, 8);
      repeat (TMO + 5) tick();
      chk("timeout_delay", tmo_cyc - stb_cyc, TMO);
      chk("timeout_slot", slot, 0);

      // Press landing on the expiry cycle wins
      c0 = cyc;
      press(4'd2, 4'd8, 8, 8);
      while (cyc < c0 + TMO) tick();
      press(4'd1, 4'd9, 8, 8);
      chk("aligned_press_cycle", stb_cyc, c0 + LAT + TMO);
      repeat (10) tick();
      chk("aligned_slot", slot, 2);

      // Reset while in S2
      async_reset("rst_s2");
      repeat (12) tick();

      // Reset mid-debounce with the key held through release
      A = 4'd7; B = 4'd7; enter_n = 1'b0;
      repeat (3) tick();
      async_reset("rst_deb");
      mark = n_stb;
      repeat (20) tick();
      chk("held_through_reset", n_stb - mark, 0);
      enter_n = 1'b1;
      repeat (12) tick();
      press(4'd5, 4'd5, 8, 8);
      chk("press_after_release", slot, 1);

      // Randomised entries
      noise = 1;
      for (int i = 0; i < 40; i++) begin
         int r;
         logic [3:0] a, b;
         r = $urandom_range(9, 0);
         if (r == 0) begin
            a = 4'd0; b = 4'd0;
         end else if (r == 1) begin
            a = 4'($urandom_range(15, 10)); b = 4'($urandom);
            if ($urandom_range(1, 0) == 1) begin a = b; b = 4'($urandom_range(15, 10)); end
         end else begin
            a = 4'($urandom_range(9, 0)); b = 4'($urandom_range(9, 0));
         end
         press(a, b, $urandom_range(10, 6),
               ($urandom_range(4, 0) == 0) ? $urandom_range(64, 45) : $urandom_range(11, 6));
      end
      repeat (TMO + 10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
